// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_pkg
// Description : Shared defaults and types for the issue-side register/CSR
//               scoreboard (register count, address width, in-flight limit,
//               per-register pending-count width).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_scoreboard_pkg;

  localparam int SB_ADDR_W       = 5;   // architectural register address width
  localparam int SB_NREGS        = 32;  // GPR count (16 for RV32E)
  localparam int SB_MAX_INFLIGHT = 3;   // EXU + LSU + WBU occupancy
  localparam int SB_PEND_W       = 2;   // per-register pending-count width

  typedef logic [SB_ADDR_W-1:0] sb_addr_t;

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/sb_pend_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_pend_counter
// Description : Up/down pending counter. Simultaneous inc and dec leave the
//               count unchanged. A decrement of zero holds zero and raises
//               underflow_o for that cycle.
// Ports       : clk, rst (async, active-high)
//               inc_i / dec_i   - count up / down request
//               cnt_o           - current registered count
//               underflow_o     - decrement requested while count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module sb_pend_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        underflow_o = 1'b1;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

`ifndef SYNTHESIS
  // The count must never wrap past its all-ones maximum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inc_i && !dec_i && (&cnt_q)))
        else $error("sb_pend_counter: increment beyond maximum count");
    end
  end
`endif

endmodule : sb_pend_counter
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Issue-side hazard controller between IDU and EXU. Counts
//               in-flight writes per GPR and to CSRs, plus total in-flight
//               instructions, and stalls the IDU->EXU handshake on RAW/CSR
//               hazards or when the in-flight limit is reached.
// Ports       : clk, rst (async, active-high)
//               idu_valid/idu_ready_o, exu_valid_o/exu_ready - gated handshake
//               rs1/rs2 addr+used, rd_addr/rd_wen, csr_acc   - issuing instr
//               wb_fire, wb_rd_addr, wb_rd_wen, wb_csr       - retirement
//               stall, busy, err                             - status
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREGS        = SB_NREGS,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int PEND_W       = SB_PEND_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 idu_valid,
  output logic                 idu_ready_o,
  output logic                 exu_valid_o,
  input  logic                 exu_ready,
  input  logic [SB_ADDR_W-1:0] rs1_addr,
  input  logic [SB_ADDR_W-1:0] rs2_addr,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [SB_ADDR_W-1:0] rd_addr,
  input  logic                 rd_wen,
  input  logic                 csr_acc,
  input  logic                 wb_fire,
  input  logic [SB_ADDR_W-1:0] wb_rd_addr,
  input  logic                 wb_rd_wen,
  input  logic                 wb_csr,
  output logic                 stall,
  output logic                 busy,
  output logic                 err
);

  localparam int NSLOT = 2 ** SB_ADDR_W;
  // One bit of headroom so the full compare never aliases a wrapped count.
  localparam int INF_W = PEND_W + 1;

  // Indexed directly by any 5-bit address. Slot 0 (x0) and slots >= NREGS
  // have no counter and read as zero, so they never stall and are never counted.
  logic [PEND_W-1:0] w_pend [NSLOT];
  logic [NSLOT-1:0]  w_pend_uf;
  logic [PEND_W-1:0] w_csr_pend;
  logic              w_csr_uf;
  logic [INF_W-1:0]  w_inflight;
  logic              w_inf_uf;
  logic              w_issue_fire;
  logic              w_full;
  logic              w_rs1_haz;
  logic              w_rs2_haz;
  logic              w_csr_haz;
  logic              err_q;
  logic              err_d;

  genvar r;
  generate
    for (r = 0; r < NSLOT; r++) begin : g_pend
      if (r == 0 || r >= NREGS) begin : g_untracked
        assign w_pend[r]    = '0;
        assign w_pend_uf[r] = 1'b0;
      end else begin : g_tracked
        logic w_inc;
        logic w_dec;
        assign w_inc = w_issue_fire & rd_wen  & (rd_addr    == SB_ADDR_W'(r));
        assign w_dec = wb_fire      & wb_rd_wen & (wb_rd_addr == SB_ADDR_W'(r));
        sb_pend_counter #(.WIDTH(PEND_W)) u_cnt (
          .clk        (clk),
          .rst        (rst),
          .inc_i      (w_inc),
          .dec_i      (w_dec),
          .cnt_o      (w_pend[r]),
          .underflow_o(w_pend_uf[r])
        );
      end
    end
  endgenerate

  sb_pend_counter #(.WIDTH(PEND_W)) u_csr_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (w_issue_fire & csr_acc),
    .dec_i      (wb_fire & wb_csr),
    .cnt_o      (w_csr_pend),
    .underflow_o(w_csr_uf)
  );

  sb_pend_counter #(.WIDTH(INF_W)) u_inflight_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (w_issue_fire),
    .dec_i      (wb_fire),
    .cnt_o      (w_inflight),
    .underflow_o(w_inf_uf)
  );

  // Hazards look only at registered counts: a producer retiring this cycle
  // writes the RF on this edge, so its consumer issues on the next cycle.
  // This also keeps wb_* off every combinational path to stall/ready.
  assign w_rs1_haz = rs1_used & (w_pend[rs1_addr] != '0);
  assign w_rs2_haz = rs2_used & (w_pend[rs2_addr] != '0);
  assign w_csr_haz = csr_acc  & (w_csr_pend != '0);
  assign w_full    = (w_inflight == INF_W'(MAX_INFLIGHT));

  assign stall        = w_rs1_haz | w_rs2_haz | w_csr_haz | w_full;
  assign w_issue_fire = idu_valid & exu_ready & ~stall;
  assign exu_valid_o  = idu_valid & ~stall;
  assign idu_ready_o  = exu_ready & ~stall;
  assign busy         = (w_inflight != '0);

  assign err_d = err_q | (|w_pend_uf) | w_csr_uf | w_inf_uf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed self-checking bench for regfile_scoreboard with
//               hand-computed expectations (MAX_INFLIGHT = 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       idu_valid;
  logic       idu_ready_o;
  logic       exu_valid_o;
  logic       exu_ready;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       rs1_used;
  logic       rs2_used;
  logic [4:0] rd_addr;
  logic       rd_wen;
  logic       csr_acc;
  logic       wb_fire;
  logic [4:0] wb_rd_addr;
  logic       wb_rd_wen;
  logic       wb_csr;
  logic       stall;
  logic       busy;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .NREGS       (32),
    .MAX_INFLIGHT(3),
    .PEND_W      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .idu_valid  (idu_valid),
    .idu_ready_o(idu_ready_o),
    .exu_valid_o(exu_valid_o),
    .exu_ready  (exu_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .rd_addr    (rd_addr),
    .rd_wen     (rd_wen),
    .csr_acc    (csr_acc),
    .wb_fire    (wb_fire),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_wen  (wb_rd_wen),
    .wb_csr     (wb_csr),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idu(input logic v, input logic [4:0] s1, input logic u1,
                     input logic [4:0] s2, input logic u2,
                     input logic [4:0] d, input logic w, input logic c);
    idu_valid = v;
    rs1_addr  = s1;
    rs1_used  = u1;
    rs2_addr  = s2;
    rs2_used  = u2;
    rd_addr   = d;
    rd_wen    = w;
    csr_acc   = c;
  endtask

  task automatic wb(input logic f, input logic [4:0] a, input logic w, input logic c);
    wb_fire    = f;
    wb_rd_addr = a;
    wb_rd_wen  = w;
    wb_csr     = c;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    exu_ready = 1'b1;
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state: handshake passes straight through
    idu(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_exu_valid", exu_valid_o, 1'b1);
    check("rst_idu_ready", idu_ready_o, 1'b1);

    // EXU not ready: nothing issues
    idu(1, 0, 0, 0, 0, 5, 1, 0);
    exu_ready = 1'b0;
    #1;
    check("nordy_idu_ready", idu_ready_o, 1'b0);
    check("nordy_exu_valid", exu_valid_o, 1'b1);
    cyc();
    exu_ready = 1'b1;
    #1;
    check("nordy_busy", busy, 1'b0);

    // addi x5, x0, imm then consumer of x5
    idu(1, 0, 1, 0, 0, 5, 1, 0);
    #1;
    check("x0_src_nostall", stall, 1'b0);
    cyc();
    check("issue_busy", busy, 1'b1);
    idu(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    check("raw_stall", stall, 1'b1);
    check("raw_exu_valid", exu_valid_o, 1'b0);
    check("raw_idu_ready", idu_ready_o, 1'b0);
    cyc();
    check("raw_stall_hold", stall, 1'b1);
    wb(1, 5, 1, 0);
    #1;
    check("raw_no_bypass", stall, 1'b1);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("raw_release", stall, 1'b0);
    check("raw_release_valid", exu_valid_o, 1'b1);
    cyc();                                  // consumer (rd=x6) issues
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 6, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("raw_drain_busy", busy, 1'b0);

    // WAW: two writes to x7 then a reader
    idu(1, 0, 0, 0, 0, 7, 1, 0);
    cyc();
    cyc();
    idu(1, 7, 1, 0, 0, 0, 0, 0);
    #1;
    check("waw_stall", stall, 1'b1);
    wb(1, 7, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("waw_after_first", stall, 1'b1);
    wb(1, 7, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("waw_after_second", stall, 1'b0);
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("waw_busy", busy, 1'b0);

    // Same-cycle issue and retire of x3 leaves pend[3]=1, inflight=1
    idu(1, 0, 0, 0, 0, 3, 1, 0);
    cyc();
    wb(1, 3, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    idu(1, 3, 1, 0, 0, 0, 0, 0);
    #1;
    check("same_cyc_stall", stall, 1'b1);
    check("same_cyc_busy", busy, 1'b1);
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 3, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    idu(1, 3, 1, 0, 0, 0, 0, 0);
    #1;
    check("same_cyc_clear", stall, 1'b0);
    check("same_cyc_idle", busy, 1'b0);
    idu(0, 0, 0, 0, 0, 0, 0, 0);

    // Full: three independent issues, fourth stalls even with wb_fire
    idu(1, 0, 0, 0, 0, 10, 1, 0);
    cyc();
    idu(1, 0, 0, 0, 0, 11, 1, 0);
    cyc();
    idu(1, 0, 0, 0, 0, 12, 1, 0);
    cyc();
    idu(1, 0, 0, 0, 0, 13, 1, 0);
    #1;
    check("full_stall", stall, 1'b1);
    check("full_idu_ready", idu_ready_o, 1'b0);
    wb(1, 10, 1, 0);
    #1;
    check("full_with_wb", stall, 1'b1);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("full_resume", stall, 1'b0);
    cyc();                                  // x13 issues
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 11, 1, 0);
    cyc();
    wb(1, 12, 1, 0);
    cyc();
    wb(1, 13, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("full_drain_busy", busy, 1'b0);

    // CSR: csrrw x0 then csrr stalls; x0-only instruction never stalls
    idu(1, 0, 1, 0, 0, 0, 1, 1);
    #1;
    check("csr_first", stall, 1'b0);
    cyc();
    idu(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("csr_raw", stall, 1'b1);
    idu(1, 0, 1, 0, 1, 0, 1, 0);
    #1;
    check("x0_nostall", stall, 1'b0);
    cyc();                                  // x0-writer issues, inflight=2
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 0, 1, 1);
    cyc();
    wb(1, 0, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("x0_no_err", err, 1'b0);
    check("csr_drain_busy", busy, 1'b0);
    idu(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("csr_clear", stall, 1'b0);
    idu(0, 0, 0, 0, 0, 0, 0, 0);

    // Underflow on x9 with inflight non-zero -> sticky err
    idu(1, 0, 0, 0, 0, 10, 1, 0);
    cyc();
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 9, 1, 0);
    cyc();
    wb(0, 0, 0, 0);
    #1;
    check("uf_err", err, 1'b1);
    check("uf_busy", busy, 1'b0);
    repeat (3) cyc();
    check("uf_err_sticky", err, 1'b1);
    idu(1, 10, 1, 0, 0, 0, 0, 0);
    #1;
    check("pend10_live", stall, 1'b1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_err", err, 1'b0);
    check("arst_stall", stall, 1'b0);
    check("arst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    idu(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    idu(1, 10, 1, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_stall", stall, 1'b0);
    check("post_rst_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_scoreboard
`default_nettype wire
